oto_pilot_v2: RTL and testbench

OTO_PILOT_V2 -- requirements
Module: oto_pilot_v2

---
 rtl/oto_pilot_pkg.sv | 19 +
 rtl/oto_pilot_v2_sensor_fusion.sv | 50 +++++
 rtl/oto_pilot_v2.sv | 145 ++++++++++++++
 tb/tb_oto_pilot_v2.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/oto_pilot_pkg.sv
// Shared state encoding and default parameter values for the oto_pilot_v2 autopilot.
package oto_pilot_pkg;

  typedef enum logic [1:0] {
    BEKLE = 2'd0,
    UCUS  = 2'd1,
    ACIL  = 2'd2
  } state_t;

  localparam int W_DEF        = 8;
  localparam int ALT_MIN_DEF  = 10;
  localparam int ALT_MAX_DEF  = 200;
  localparam int DIFF_MAX_DEF = 9;
  localparam int HYST_DEF     = 2;
  localparam int MAX_ERR_DEF  = 3;
  localparam int ACIL_CYC_DEF = 16;
  localparam int SNS_TMO_DEF  = 8;

endpackage

// File: rtl/oto_pilot_v2_sensor_fusion.sv
// GNSS / altimeter fusion: picks, averages or holds the altitude estimate.
module sensor_fusion
  import oto_pilot_pkg::*;
#(
  parameter int W        = W_DEF,
  parameter int DIFF_MAX = DIFF_MAX_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] gnss,
  input  logic         gnss_valid,
  input  logic [W-1:0] alt,
  input  logic         alt_valid,
  output logic [W-1:0] fused_p0,
  output logic         vld_p0
);

  localparam logic [W-1:0] DLIM = W'(DIFF_MAX);

  logic [W-1:0] fused_p1;

  function automatic logic [W-1:0] avg_floor(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[W:1];
  endfunction

  function automatic logic [W-1:0] abs_diff(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a >= b) ? a - b : b - a;
  endfunction

  assign vld_p0 = gnss_valid | alt_valid;

  always_comb begin
    fused_p0 = fused_p1;
    unique case ({gnss_valid, alt_valid})
      2'b11:   fused_p0 = (abs_diff(gnss, alt) > DLIM) ? gnss : avg_floor(gnss, alt);
      2'b10:   fused_p0 = gnss;
      2'b01:   fused_p0 = alt;
      default: fused_p0 = fused_p1;
    endcase
  end

  // p0 -> p1: hold register, keeps the last estimate while no sensor is valid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fused_p1 <= '0;
    else      fused_p1 <= fused_p0;
  end

endmodule

// File: rtl/oto_pilot_v2.sv
// Altitude autopilot: target handling, fault counting, emergency hold and motor control.
module oto_pilot_v2
  import oto_pilot_pkg::*;
#(
  parameter int W        = W_DEF,
  parameter int ALT_MIN  = ALT_MIN_DEF,
  parameter int ALT_MAX  = ALT_MAX_DEF,
  parameter int DIFF_MAX = DIFF_MAX_DEF,
  parameter int HYST     = HYST_DEF,
  parameter int MAX_ERR  = MAX_ERR_DEF,
  parameter int ACIL_CYC = ACIL_CYC_DEF,
  parameter int SNS_TMO  = SNS_TMO_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [W-1:0]                 gnss_i,
  input  logic                         gnss_valid_i,
  input  logic [W-1:0]                 alt_i,
  input  logic                         alt_valid_i,
  input  logic [W-1:0]                 hedef_i,
  input  logic                         hedef_valid_i,
  input  logic                         iptal_i,
  output logic                         motor_o,
  output logic                         yesil_led_o,
  output logic                         kirmizi_led_o,
  output logic [1:0]                   state_o,
  output logic [$clog2(MAX_ERR+1)-1:0] hata_o
);

  localparam int HW = $clog2(MAX_ERR + 1);
  localparam int TW = $clog2(SNS_TMO + 1);
  localparam int AW = (ACIL_CYC > 1) ? $clog2(ACIL_CYC) : 1;

  localparam logic [W-1:0]  LO        = W'(ALT_MIN);
  localparam logic [W-1:0]  HI        = W'(ALT_MAX);
  localparam logic [W-1:0]  HY        = W'(HYST);
  localparam logic [HW-1:0] ERR_LIM   = HW'(MAX_ERR);
  localparam logic [TW-1:0] TMO_LIM   = TW'(SNS_TMO);
  localparam logic [AW-1:0] ACIL_LAST = AW'(ACIL_CYC - 1);

  state_t        state, state_nx;
  logic [W-1:0]  target, target_nx;
  logic [HW-1:0] hata, hata_nx;
  logic [TW-1:0] tmo, tmo_nx;
  logic [AW-1:0] acil_cnt, acil_nx;
  logic          motor_nx, yesil_nx, kirmizi_nx;
  logic [W-1:0]  fused_p0;
  logic          vld_p0;
  logic          legal, tmo_hit;

  function automatic logic [W-1:0] sat_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a > b) ? a - b : '0;
  endfunction

  sensor_fusion #(
    .W        (W),
    .DIFF_MAX (DIFF_MAX)
  ) u_fusion (
    .clk        (clk),
    .rst        (rst),
    .gnss       (gnss_i),
    .gnss_valid (gnss_valid_i),
    .alt        (alt_i),
    .alt_valid  (alt_valid_i),
    .fused_p0   (fused_p0),
    .vld_p0     (vld_p0)
  );

  assign legal   = (hedef_i >= LO) && (hedef_i <= HI);
  assign tmo_nx  = vld_p0 ? '0 : ((tmo == TMO_LIM) ? tmo : tmo + 1'b1);
  assign tmo_hit = (tmo_nx == TMO_LIM);

  // Priority: abort, then sensor timeout, then error limit, then target strobe.
  always_comb begin
    state_nx  = state;
    target_nx = target;
    hata_nx   = hata;
    acil_nx   = '0;
    case (state)
      BEKLE, UCUS: begin
        if (iptal_i) begin
          state_nx = BEKLE;
        end else if ((state == UCUS) && tmo_hit) begin
          state_nx = ACIL;
        end else if (hedef_valid_i) begin
          if (legal) begin
            target_nx = hedef_i;
            state_nx  = UCUS;
          end else begin
            hata_nx = hata + 1'b1;
            if (hata_nx == ERR_LIM) state_nx = ACIL;
          end
        end
      end
      ACIL: begin
        if (acil_cnt == ACIL_LAST) begin
          state_nx = BEKLE;
          hata_nx  = '0;
        end else begin
          acil_nx = acil_cnt + 1'b1;
        end
      end
      default: state_nx = BEKLE;
    endcase
  end

  // Motor decision uses the estimate and target that become current next cycle.
  always_comb begin
    motor_nx   = 1'b0;
    yesil_nx   = 1'b0;
    kirmizi_nx = (state_nx == ACIL);
    if (state_nx == UCUS) begin
      if (fused_p0 < sat_sub(target_nx, HY)) motor_nx = 1'b1;
      else if (fused_p0 >= target_nx)        motor_nx = 1'b0;
      else                                   motor_nx = motor_o;
      yesil_nx = !motor_nx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= BEKLE;
      target        <= '0;
      hata          <= '0;
      tmo           <= '0;
      acil_cnt      <= '0;
      motor_o       <= 1'b0;
      yesil_led_o   <= 1'b0;
      kirmizi_led_o <= 1'b0;
    end else begin
      state         <= state_nx;
      target        <= target_nx;
      hata          <= hata_nx;
      tmo           <= tmo_nx;
      acil_cnt      <= acil_nx;
      motor_o       <= motor_nx;
      yesil_led_o   <= yesil_nx;
      kirmizi_led_o <= kirmizi_nx;
    end
  end

  assign state_o = state;
  assign hata_o  = hata;

endmodule

// File: tb/tb_oto_pilot_v2.sv
// Directed, table-driven bench for oto_pilot_v2 with hand-computed expectations.
module tb_oto_pilot_v2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] gnss, alt, hedef;
  logic       gnss_valid, alt_valid, hedef_valid, iptal;
  logic       motor, yesil, kirmizi;
  logic [1:0] state, hata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  oto_pilot_v2 dut (
    .clk           (clk),
    .rst           (rst),
    .gnss_i        (gnss),
    .gnss_valid_i  (gnss_valid),
    .alt_i         (alt),
    .alt_valid_i   (alt_valid),
    .hedef_i       (hedef),
    .hedef_valid_i (hedef_valid),
    .iptal_i       (iptal),
    .motor_o       (motor),
    .yesil_led_o   (yesil),
    .kirmizi_led_o (kirmizi),
    .state_o       (state),
    .hata_o        (hata)
  );

  typedef struct {
    logic [7:0] g;
    logic       gv;
    logic [7:0] a;
    logic       av;
    logic [7:0] h;
    logic       hv;
    logic       ip;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[21];

  // Expected output word: {state, motor, yesil, kirmizi, hata}
  function automatic logic [6:0] e(input int st, input int m, input int y, input int k, input int h);
    return {st[1:0], m[0], y[0], k[0], h[1:0]};
  endfunction

  function automatic vec_t v(input int g, input int gv, input int a, input int av,
                             input int h, input int hv, input int ip, input logic [6:0] ex);
    vec_t r;
    r.g = g[7:0];  r.gv = gv[0];
    r.a = a[7:0];  r.av = av[0];
    r.h = h[7:0];  r.hv = hv[0];
    r.ip = ip[0];  r.exp = ex;
    return r;
  endfunction

  function automatic logic [6:0] outs();
    return {state, motor, yesil, kirmizi, hata};
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: st/m/y/k/hata got %b required %b", name, act, req);
    end
  endtask

  task automatic drive(input int g, input int gv, input int a, input int av,
                       input int h, input int hv, input int ip);
    gnss = g[7:0];  gnss_valid = gv[0];
    alt  = a[7:0];  alt_valid  = av[0];
    hedef = h[7:0]; hedef_valid = hv[0];
    iptal = ip[0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset in the middle of a cycle, outputs checked before any edge.
  task automatic pulse_reset(input string name);
    #2 rst = 1'b0;
    #1 check(name, outs(), 7'b0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    vecs[0]  = v( 50,1, 50,1, 100,1, 0, e(1,1,0,0,0));
    vecs[1]  = v( 99,1, 99,1,   0,0, 0, e(1,1,0,0,0));
    vecs[2]  = v(100,1,100,1,   0,0, 0, e(1,0,1,0,0));
    vecs[3]  = v( 50,1, 50,1,   0,0, 0, e(1,1,0,0,0));
    vecs[4]  = v( 60,1, 80,1,  60,1, 0, e(1,0,1,0,0));
    vecs[5]  = v( 60,1, 80,1,  63,1, 0, e(1,1,0,0,0));
    vecs[6]  = v( 70,1, 75,1,  72,1, 0, e(1,0,1,0,0));
    vecs[7]  = v( 70,1, 75,1,  75,1, 0, e(1,1,0,0,0));
    vecs[8]  = v(200,0, 90,1,  90,1, 0, e(1,0,1,0,0));
    vecs[9]  = v(200,0, 90,1,  93,1, 0, e(1,1,0,0,0));
    vecs[10] = v(  5,0,  5,0,  90,1, 0, e(1,0,1,0,0));
    vecs[11] = v( 95,1, 95,1,   5,1, 0, e(1,0,1,0,1));
    vecs[12] = v( 95,1, 95,1, 201,1, 0, e(1,0,1,0,2));
    vecs[13] = v( 95,1, 95,1, 200,1, 0, e(1,1,0,0,2));
    vecs[14] = v(250,1,245,1,   0,0, 0, e(1,0,1,0,2));
    vecs[15] = v(199,1,190,1,   0,0, 0, e(1,1,0,0,2));
    vecs[16] = v(200,1,190,1,   0,0, 0, e(1,0,1,0,2));
    vecs[17] = v( 95,1, 95,1,   0,0, 1, e(0,0,0,0,2));
    vecs[18] = v(  5,1,  5,1,  10,1, 0, e(1,1,0,0,2));
    vecs[19] = v(  5,1,  5,1,   0,0, 1, e(0,0,0,0,2));
    vecs[20] = v(  5,1,  5,1,   9,1, 0, e(2,0,0,1,3));

    drive(0, 0, 0, 0, 0, 0, 0);
    #12 check("reset_state", outs(), 7'b0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].g, vecs[i].gv, vecs[i].a, vecs[i].av, vecs[i].h, vecs[i].hv, vecs[i].ip);
      tick();
      check($sformatf("row%0d", i), outs(), vecs[i].exp);
    end

    // Emergency hold: 16 cycles in total, abort requests ignored throughout.
    for (int i = 1; i < 16; i++) begin
      drive(50, 1, 50, 1, 0, 0, i % 2);
      tick();
      check($sformatf("acil_hold%0d", i), outs(), e(2,0,0,1,3));
    end
    drive(50, 1, 50, 1, 0, 0, 0);
    tick();
    check("acil_exit", outs(), e(0,0,0,0,0));

    // Three illegal targets from idle, then reset mid-emergency.
    drive(50, 1, 50, 1, 5, 1, 0);
    tick(); check("bad_tgt1", outs(), e(0,0,0,0,1));
    tick(); check("bad_tgt2", outs(), e(0,0,0,0,2));
    tick(); check("bad_tgt3", outs(), e(2,0,0,1,3));
    drive(50, 1, 50, 1, 0, 0, 1);
    tick(); check("acil_ignores_iptal", outs(), e(2,0,0,1,3));
    drive(50, 1, 50, 1, 0, 0, 0);
    tick();
    pulse_reset("reset_mid_acil");
    drive(50, 1, 50, 1, 5, 1, 0);
    tick(); check("post_reset_bad", outs(), e(0,0,0,0,1));
    drive(50, 1, 50, 1, 100, 1, 0);
    tick(); check("post_reset_legal", outs(), e(1,1,0,0,1));

    // Sensor timeout in flight, reset mid-flight first.
    pulse_reset("reset_mid_flight");
    drive(50, 1, 50, 1, 100, 1, 0);
    tick(); check("tmo_enter", outs(), e(1,1,0,0,0));
    for (int i = 1; i < 8; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      tick();
      check($sformatf("tmo_wait%0d", i), outs(), e(1,1,0,0,0));
    end
    tick(); check("tmo_acil", outs(), e(2,0,0,1,0));

    // Same timeout, but abort on the eighth silent cycle wins.
    pulse_reset("reset_mid_acil2");
    drive(50, 1, 50, 1, 100, 1, 0);
    tick(); check("tmo2_enter", outs(), e(1,1,0,0,0));
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i < 8; i++) tick();
    check("tmo2_wait7", outs(), e(1,1,0,0,0));
    drive(0, 0, 0, 0, 0, 0, 1);
    tick(); check("tmo_iptal_wins", outs(), e(0,0,0,0,0));
    drive(0, 0, 0, 0, 0, 0, 0);
    tick(); check("idle_no_tmo", outs(), e(0,0,0,0,0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
